pipe_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage ARM pipeline. Drives ld/flush of PC, IF/ID, ID/EX, EX/MEM
//  and MEM/WB registers. Resolves three events: data (load-use) hazard, taken branch, multi-cycle memory wait.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding and register index width.
// Latency: n/a (types only). Backpressure: n/a.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// RAW hazard compare of the ID sources against in-flight destinations.
// Latency: combinational. Backpressure: none; the result feeds the stall decode.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FWD_EN = 1
) (
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_two_src,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  output logic                 hz
);

  logic exe_qual;
  logic exe_hit;
  logic mem_hit;

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign exe_qual = (FWD_EN != 0) ? exe_mem_r_en : exe_wb_en;

  always_comb begin
    exe_hit = exe_qual & ((id_src1 == exe_dest) | (id_two_src & (id_src2 == exe_dest)));
    mem_hit = 1'b0;
    if (FWD_EN == 0) begin
      mem_hit = mem_wb_en & ((id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest)));
    end
    hz = exe_hit | mem_hit;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer owning every stage ld/flush; Mealy outputs (same cycle as inputs).
// Backpressure: memory wait freezes the whole pipe; load-use holds PC and IF/ID while bubbling ID/EX.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FWD_EN      = 1,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_two_src,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  input  logic                 br_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_ld,
  output logic                 if_id_ld,
  output logic                 if_id_flush,
  output logic                 id_ex_ld,
  output logic                 id_ex_flush,
  output logic                 ex_mem_ld,
  output logic                 mem_wb_ld,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 mem_to_err
);

  localparam int WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              err_q, err_d;
  logic              hz;
  logic              flow;

  hazard_detect #(
    .FWD_EN(FWD_EN)
  ) u_hazard_detect (
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .exe_dest    (exe_dest),
    .exe_wb_en   (exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en),
    .mem_dest    (mem_dest),
    .mem_wb_en   (mem_wb_en),
    .hz          (hz)
  );

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    flow        = 1'b0;
    pc_ld       = 1'b0;
    if_id_ld    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_ld    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_ld   = 1'b0;
    mem_wb_ld   = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d = MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end else begin
          flow = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          flow    = 1'b1;
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q < WCNT_MAX) begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end else begin
          err_d   = 1'b1;
          state_d = TRAP;
        end
      end
      TRAP: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // A taken branch squashes the ID instruction, so its hazard is moot.
    if (flow) begin
      if (br_taken) begin
        pc_ld       = 1'b1;
        if_id_ld    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_ld    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_ld   = 1'b1;
        mem_wb_ld   = 1'b1;
      end else if (hz) begin
        id_ex_ld    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_ld   = 1'b1;
        mem_wb_ld   = 1'b1;
      end else begin
        pc_ld     = 1'b1;
        if_id_ld  = 1'b1;
        id_ex_ld  = 1'b1;
        ex_mem_ld = 1'b1;
        mem_wb_ld = 1'b1;
      end
    end

    if (!rst_n) begin
      pc_ld       = 1'b0;
      if_id_ld    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_ld    = 1'b0;
      id_ex_flush = 1'b1;
      ex_mem_ld   = 1'b0;
      mem_wb_ld   = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_ld && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign mem_to_err = err_q;

endmodule
